// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: handshaked issue sequencer and result FIFO wrapped around the combinational ALU_8bit
// Ports: cmd_* accepts {op,a,b} over valid/ready; alu_* drive/capture ALU_8bit;
//        res_* present the FIFO head over valid/ready; busy flags the DRIVE state.
// Define ALU_ISSUE_STATS_EN to add the stat_ops/stat_carry push counters.
module alu_issue_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_cout,
  output logic [2:0]  res_op,
  output logic        busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_carry
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [19:0]   mem_q [FIFO_DEPTH];
  logic [19:0]   mem_d [FIFO_DEPTH];
  logic          accept, push, pop;
  assign cmd_ready = state_q == IDLE && cnt_q < FULL;
  assign busy = state_q == DRIVE;
  assign res_valid = cnt_q != '0;
  assign {res_op, res_data, res_cout} = mem_q[rd_q];
  assign alu_opcode = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  // The ALU has had the whole DRIVE cycle to settle, so capture is unconditional there.
  always_comb begin
    accept = cmd_valid && cmd_ready;
    push = state_q == DRIVE;
    pop = res_valid && res_ready;
    state_d = accept ? DRIVE : IDLE;
    op_d = accept ? cmd_op : op_q;
    a_d = accept ? cmd_a : a_q;
    b_d = accept ? cmd_b : b_q;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    for (int i = 0; i < FIFO_DEPTH; i++)
      mem_d[i] = (push && wr_q == AW'(i)) ? {op_q, alu_out, alu_cout} : mem_q[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d, stat_carry_q, stat_carry_d;
  assign stat_ops = stat_ops_q;
  assign stat_carry = stat_carry_q;
  always_comb begin
    stat_ops_d = stat_ops_q + 16'(push);
    stat_carry_d = stat_carry_q + 16'(push && alu_cout);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_carry_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_carry_q <= stat_carry_d;
    end
  end
`endif
endmodule
